inp_cond: RTL and testbench

//  Button front end feeding the paddle-position block. Synchronises and debounces
//  the four raw player buttons. Produces clean p1up/p1down/p2up/p2down levels and
//  a periodic one-cycle input_enable strobe that sets the paddle movement rate.

---
 rtl/inp_cond.sv | 106 ++++++++++
 tb/tb_inp_cond.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/inp_cond.sv
`default_nettype none
// ============================================================================
// Module   : inp_cond
// Brief    : Player-button front end: 2-flop sync, per-button debounce,
//            up/down conflict masking and a free-running input_enable tick.
//            Build option INP_COND_ACTIVE_LOW_EN selects pulled-up (active
//            low) button pins.
// Revision : 1.0  initial release
// ============================================================================
module inp_cond #(
   parameter int DEB_CYC  = 250000,
   parameter int TICK_DIV = 416667
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn_raw,
   output logic       p1up,
   output logic       p1down,
   output logic       p2up,
   output logic       p2down,
   output logic       input_enable
);

   localparam int CW = $clog2(DEB_CYC + 1);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] c_deb_last  = CW'(DEB_CYC - 1);
   localparam logic [TW-1:0] c_tick_last = TW'(TICK_DIV - 1);

`ifdef INP_COND_ACTIVE_LOW_EN
   localparam logic [3:0] c_sync_rel = 4'hF;
`else
   localparam logic [3:0] c_sync_rel = 4'h0;
`endif

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    w_s;
   logic [3:0]    r_q;
   logic [TW-1:0] r_tick_cnt;

   // Only r_sync1 samples the asynchronous pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= c_sync_rel;
         r_sync2 <= c_sync_rel;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

`ifdef INP_COND_ACTIVE_LOW_EN
   assign w_s = ~r_sync2;
`else
   assign w_s = r_sync2;
`endif

   for (genvar g = 0; g < 4; g++) begin : g_deb
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt  <= '0;
            r_q[g] <= 1'b0;
         end else if (w_s[g] == r_q[g]) begin
            r_cnt <= '0;
         end else if (r_cnt == c_deb_last) begin
            r_q[g] <= w_s[g];
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Pressing both directions of one player cancels that player's motion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1up   <= 1'b0;
         p1down <= 1'b0;
         p2up   <= 1'b0;
         p2down <= 1'b0;
      end else begin
         p1up   <= r_q[0] & ~r_q[1];
         p1down <= r_q[1] & ~r_q[0];
         p2up   <= r_q[2] & ~r_q[3];
         p2down <= r_q[3] & ~r_q[2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt   <= '0;
         input_enable <= 1'b0;
      end else begin
         input_enable <= (r_tick_cnt == c_tick_last);
         if (r_tick_cnt == c_tick_last) begin
            r_tick_cnt <= '0;
         end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inp_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_inp_cond
// Brief    : Directed self-checking bench for inp_cond (DEB_CYC=4, TICK_DIV=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_inp_cond;

   logic       clk;
   logic       rst_n;
   logic [3:0] btn_raw;
   logic       p1up, p1down, p2up, p2down, input_enable;

   int checks   = 0;
   int failures = 0;
   int ecount   = 0;
   bit in_reset = 1'b1;

   inp_cond #(.DEB_CYC(4), .TICK_DIV(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_raw      (btn_raw),
      .p1up         (p1up),
      .p1down       (p1down),
      .p2up         (p2up),
      .p2down       (p2down),
      .input_enable (input_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Logical press pattern {p2down,p2up,p1down,p1up} to pin level.
   function automatic logic [3:0] phys(input logic [3:0] v);
`ifdef INP_COND_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic chk_ie();
      logic exp_ie;
      exp_ie = !in_reset && (ecount != 0) && ((ecount % 8) == 0);
      checks++;
      assert (input_enable === exp_ie) else begin
         failures++;
         $error("FAIL ie edge=%0d observed=%b expected=%b", ecount, input_enable, exp_ie);
      end
   endtask

   // One rising edge, sample 1 time unit later, check the tick model.
   task automatic step();
      @(posedge clk);
      #1;
      if (!in_reset) ecount++;
      chk_ie();
   endtask

   task automatic chk_out(input string tag, input logic [3:0] exp_o);
      logic [3:0] obs;
      obs = {p2down, p2up, p1down, p1up};
      checks++;
      assert (obs === exp_o) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_o);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      btn_raw = phys(4'b0000);
      #2;
      chk_out("reset_state", 4'b0000);
      chk_ie();
      step();
      step();

      // 1: reset release, strobe only on edges 8,16,24
      @(negedge clk);
      rst_n = 1'b1; in_reset = 1'b0; ecount = 0;
      for (int i = 1; i <= 24; i++) begin
         step();
         chk_out("idle", 4'b0000);
      end

      // 2: p1up press / release latency of 7 edges
      btn_raw = phys(4'b0001);
      for (int i = 1; i <= 7; i++) begin
         step();
         chk_out("p1up_press", (i >= 7) ? 4'b0001 : 4'b0000);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("p1up_hold", 4'b0001);
      end
      btn_raw = phys(4'b0000);
      for (int i = 1; i <= 7; i++) begin
         step();
         chk_out("p1up_release", (i >= 7) ? 4'b0000 : 4'b0001);
      end

      // 3: 3-cycle glitches on p2up never qualify
      for (int r = 0; r < 5; r++) begin
         btn_raw = phys(4'b0100);
         for (int i = 0; i < 3; i++) begin
            step();
            chk_out("glitch_hi", 4'b0000);
         end
         btn_raw = phys(4'b0000);
         step();
         chk_out("glitch_lo", 4'b0000);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         chk_out("glitch_settle", 4'b0000);
      end

      // 4: up+down conflict masks player 1; dropping down leaves up
      btn_raw = phys(4'b0011);
      for (int i = 0; i < 10; i++) begin
         step();
         chk_out("conflict", 4'b0000);
      end
      btn_raw = phys(4'b0001);
      for (int i = 1; i <= 7; i++) begin
         step();
         chk_out("conflict_drop", (i >= 7) ? 4'b0001 : 4'b0000);
      end
      btn_raw = phys(4'b0000);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk_out("conflict_release", (i >= 7) ? 4'b0000 : 4'b0001);
      end

      // 5: reset in the middle of a p2down debounce
      btn_raw = phys(4'b1000);
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out("p2down_pre", 4'b0000);
      end
      rst_n = 1'b0; in_reset = 1'b1;
      #1;
      chk_out("mid_reset", 4'b0000);
      chk_ie();
      step();
      chk_out("in_reset", 4'b0000);
      step();
      @(negedge clk);
      rst_n = 1'b1; in_reset = 1'b0; ecount = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         chk_out("p2down_requal", (i >= 7) ? 4'b1000 : 4'b0000);
      end
      btn_raw = phys(4'b0000);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk_out("p2down_release", (i >= 7) ? 4'b0000 : 4'b1000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
